hms_clock_display: RTL and testbench

Parametrised time-of-day counter with a multiplexed 6-digit 7-segment driver. It keeps hours, minutes and seconds in binary and scans them onto an active-low common-digit display as HH MM SS. It also exposes the time and a one-second strobe to other blocks.

---
 rtl/hms_clock_display_pkg.sv | 63 ++++++
 rtl/hms_clock_display_if.sv | 25 ++
 rtl/hms_clock_display_seg7_encode.sv | 32 +++
 rtl/hms_clock_display.sv | 159 +++++++++++++++
 tb/tb_hms_clock_display.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hms_clock_display_pkg.sv
// Shared constants, types and helpers for the HH:MM:SS clock and its
// multiplexed active-low 7-segment display.
package timer_pkg;

  // Segment patterns {dp,g,f,e,d,c,b,a}, active-low, dp off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // One-hot-low digit selects; entry 0 drives the rightmost digit.
  localparam logic [5:0] DIGIT_SEL [0:5] = '{
    6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111
  };

  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;

  // Scan position, right to left: SS, MM, HH.
  typedef enum logic [2:0] {
    D_SEC_U = 3'd0,
    D_SEC_T = 3'd1,
    D_MIN_U = 3'd2,
    D_MIN_T = 3'd3,
    D_HR_U  = 3'd4,
    D_HR_T  = 3'd5
  } digit_idx_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // Tens/units split of a 0..59 value by a compare chain (quotient <= 5).
  function automatic bcd_t div10(input logic [5:0] value);
    bcd_t       res;
    logic [5:0] rem;
    if (value >= 6'd50) begin
      res.tens = 4'd5; rem = value - 6'd50;
    end else if (value >= 6'd40) begin
      res.tens = 4'd4; rem = value - 6'd40;
    end else if (value >= 6'd30) begin
      res.tens = 4'd3; rem = value - 6'd30;
    end else if (value >= 6'd20) begin
      res.tens = 4'd2; rem = value - 6'd20;
    end else if (value >= 6'd10) begin
      res.tens = 4'd1; rem = value - 6'd10;
    end else begin
      res.tens = 4'd0; rem = value;
    end
    res.units = 4'(rem);
    return res;
  endfunction

endpackage

// File: rtl/hms_clock_display_if.sv
// Control inputs and time/display outputs of the clock, bundled.
interface hms_clock_display_if;
  logic       run;
  logic       inc_m;
  logic       inc_h;
  logic       clr_s;
  logic [7:0] number;
  logic [5:0] digit_block;
  logic       sec_tick;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;

  // Controller side: drives controls, observes time and display.
  modport master (
    output run, inc_m, inc_h, clr_s,
    input  number, digit_block, sec_tick, hours, minutes, seconds
  );

  // Clock side.
  modport slave (
    input  run, inc_m, inc_h, clr_s,
    output number, digit_block, sec_tick, hours, minutes, seconds
  );
endinterface

// File: rtl/hms_clock_display_seg7_encode.sv
// BCD digit to active-low segments {g,f,e,d,c,b,a}; blank or digits
// above 9 turn every segment off.
module seg7_encode
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup for the selected digit.
  always_comb begin
    // NOTE: default assigned first so every path drives seg; no latch.
    seg = SEG_BLANK[6:0];
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0[6:0];
        4'd1:    seg = SEG_1[6:0];
        4'd2:    seg = SEG_2[6:0];
        4'd3:    seg = SEG_3[6:0];
        4'd4:    seg = SEG_4[6:0];
        4'd5:    seg = SEG_5[6:0];
        4'd6:    seg = SEG_6[6:0];
        4'd7:    seg = SEG_7[6:0];
        4'd8:    seg = SEG_8[6:0];
        4'd9:    seg = SEG_9[6:0];
        default: seg = SEG_BLANK[6:0];
      endcase
    end
  end

endmodule

// File: rtl/hms_clock_display.sv
// Time-of-day counter (HH:MM:SS) with run/hold, manual set, 12/24-hour
// display and a multiplexed 6-digit active-low 7-segment driver.
module hms_clock_display
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned SCAN_DIV     = 50_000,
  parameter bit          HOUR_MODE_12 = 1'b0
) (
  input logic                clk,
  input logic                rst,
  hms_clock_display_if.slave bus
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_HALF = PRE_W'(TICK_DIV / 2);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]  pre;
  logic [SCAN_W-1:0] scan_cnt;
  digit_idx_e        idx;
  digit_idx_e        idx_next;
  logic              scan_wrap;

  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;

  logic       tick;
  logic       sec_wrap;
  logic       min_carry;
  logic       hour_carry;

  logic [5:0] hour_shown;
  bcd_t       sec_bcd;
  bcd_t       min_bcd;
  bcd_t       hr_bcd;
  logic [3:0] digit_val;
  logic       blank;
  logic       dp_on;
  logic       pm;
  logic       sep_on;
  logic [6:0] seg_bits;
  logic [7:0] number;
  logic [7:0] number_next;
  logic [5:0] digit_block;
  logic [5:0] digit_next;

  // A tick is the prescaler wrap; clr_s suppresses it. inc_m/inc_h absorb
  // any coincident carry, since both effects are the same +1.
  assign tick       = bus.run && !bus.clr_s && (pre == PRE_MAX);
  assign sec_wrap   = tick && (seconds == MAX_SEC);
  assign min_carry  = sec_wrap && !bus.inc_m;
  assign hour_carry = min_carry && (minutes == MAX_MIN);

  // Prescaler, time counters and the one-second strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre      <= '0;
      seconds  <= '0;
      minutes  <= '0;
      hours    <= '0;
      sec_tick <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      sec_tick <= tick;
      if (bus.clr_s)   pre <= '0;
      else if (bus.run) pre <= (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);

      if (bus.clr_s)   seconds <= '0;
      else if (tick)   seconds <= (seconds == MAX_SEC) ? '0 : seconds + 6'd1;

      if (bus.inc_m || min_carry)
        minutes <= (minutes == MAX_MIN) ? '0 : minutes + 6'd1;

      if (bus.inc_h || hour_carry)
        hours <= (hours == MAX_HOUR) ? '0 : hours + 5'd1;
    end
  end

  // Scan FSM state register: per-digit dwell counter and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= D_SEC_U;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      idx      <= idx_next;
    end
  end

  // Scan FSM next state: step to the next digit at the end of each dwell.
  always_comb begin
    scan_wrap = (scan_cnt == SCAN_MAX);
    idx_next  = idx;
    if (scan_wrap)
      idx_next = (idx == D_HR_T) ? D_SEC_U : digit_idx_e'(idx + 3'd1);
  end

  // Scan FSM outputs: digit value, blanking and dp for the next digit.
  always_comb begin
    hour_shown = {1'b0, hours};
    if (HOUR_MODE_12) begin
      if (hours == 5'd0)       hour_shown = 6'd12;
      else if (hours > 5'd12)  hour_shown = {1'b0, hours} - 6'd12;
    end
    sec_bcd   = div10(seconds);
    min_bcd   = div10(minutes);
    hr_bcd    = div10(hour_shown);
    pm        = HOUR_MODE_12 && (hours >= 5'd12);
    sep_on    = !bus.run || (pre < PRE_HALF);
    digit_val = 4'd0;
    blank     = 1'b0;
    dp_on     = 1'b0;
    case (idx_next)
      D_SEC_U: begin digit_val = sec_bcd.units; dp_on = pm;     end
      D_SEC_T: digit_val = sec_bcd.tens;
      D_MIN_U: begin digit_val = min_bcd.units; dp_on = sep_on; end
      D_MIN_T: digit_val = min_bcd.tens;
      D_HR_U:  begin digit_val = hr_bcd.units;  dp_on = sep_on; end
      D_HR_T:  begin
        digit_val = hr_bcd.tens;
        blank     = HOUR_MODE_12 && (hr_bcd.tens == 4'd0);
      end
      default: digit_val = 4'd0;
    endcase
  end

  seg7_encode u_seg7 (
    .digit (digit_val),
    .blank (blank),
    .seg   (seg_bits)
  );

  assign number_next = {~dp_on, seg_bits};
  assign digit_next  = DIGIT_SEL[idx_next];

  // Segment data and digit select load together on the scan edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      number      <= SEG_0;
      digit_block <= DIGIT_SEL[0];
    end else if (scan_wrap) begin
      number      <= number_next;
      digit_block <= digit_next;
    end
  end

  assign bus.number      = number;
  assign bus.digit_block = digit_block;
  assign bus.sec_tick    = sec_tick;
  assign bus.hours       = hours;
  assign bus.minutes     = minutes;
  assign bus.seconds     = seconds;

endmodule

// File: tb/tb_hms_clock_display.sv
// Scoreboard bench: a 24-hour and a 12-hour instance receive the same
// stimulus; a behavioural model queues expected time and display values.
module tb_hms_clock_display;

  localparam int TICK = 4;
  localparam int SCAN = 2;

  // Independent segment table {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  // Literal per-digit readings at 13:05:00 with run held low.
  localparam logic [7:0] EXP12 [0:5] = '{8'h40, 8'hC0, 8'h12, 8'hC0, 8'h79, 8'hFF};
  localparam logic [7:0] EXP24 [0:5] = '{8'hC0, 8'hC0, 8'h12, 8'hC0, 8'h30, 8'hF9};

  typedef struct {
    int         h;
    int         m;
    int         s;
    bit         tick;
    logic [5:0] db;
    logic [7:0] num24;
    logic [7:0] num12;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   tick_seen;
  exp_t sb_q[$];

  int         m_pre, m_h, m_m, m_s, m_cyc;
  logic [5:0] m_db;
  logic [7:0] m_num24, m_num12;

  hms_clock_display_if bus24 ();
  hms_clock_display_if bus12 ();

  hms_clock_display #(.TICK_DIV(TICK), .SCAN_DIV(SCAN), .HOUR_MODE_12(1'b0)) dut24 (
    .clk (clk),
    .rst (rst),
    .bus (bus24.slave)
  );

  hms_clock_display #(.TICK_DIV(TICK), .SCAN_DIV(SCAN), .HOUR_MODE_12(1'b1)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (bus12.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected display byte for digit idx from the model's current time.
  function automatic logic [7:0] exp_number(input bit mode12, input int idx, input bit r);
    int  hd, v;
    bit  blank, dp;
    logic [6:0] seg;
    hd = m_h;
    if (mode12) begin
      if (m_h == 0)      hd = 12;
      else if (m_h > 12) hd = m_h - 12;
    end
    blank = 1'b0;
    dp    = 1'b0;
    case (idx)
      0:       begin v = m_s % 10; dp = mode12 && (m_h >= 12); end
      1:       v = m_s / 10;
      2:       begin v = m_m % 10; dp = !r || (m_pre < TICK / 2); end
      3:       v = m_m / 10;
      4:       begin v = hd % 10; dp = !r || (m_pre < TICK / 2); end
      default: begin v = hd / 10; blank = mode12 && (v == 0); end
    endcase
    seg = blank ? 7'h7F : SEG_TAB[v];
    return {~dp, seg};
  endfunction

  task automatic model_reset();
    m_pre = 0; m_h = 0; m_m = 0; m_s = 0; m_cyc = 0;
    m_db = 6'b111110; m_num24 = 8'hC0; m_num12 = 8'hC0;
  endtask

  task automatic model_step(input bit r, input bit im, input bit ih, input bit cs,
                            output exp_t e);
    bit         tick;
    int         idx, ns, nm, nh;
    logic [5:0] one_hot;
    m_cyc++;
    if (m_cyc % SCAN == 0) begin
      idx     = (m_cyc / SCAN) % 6;
      one_hot = 6'b000001 << idx;
      m_db    = ~one_hot;
      m_num24 = exp_number(1'b0, idx, r);
      m_num12 = exp_number(1'b1, idx, r);
    end
    tick = r && !cs && (m_pre == TICK - 1);
    ns = m_s; nm = m_m; nh = m_h;
    if (cs) ns = 0;
    else if (tick) begin
      ns = (m_s + 1) % 60;
      if (m_s == 59 && !im) begin
        nm = (m_m + 1) % 60;
        if (m_m == 59) nh = (m_h + 1) % 24;
      end
    end
    if (im) nm = (m_m + 1) % 60;
    if (ih) nh = (m_h + 1) % 24;
    if (cs)     m_pre = 0;
    else if (r) m_pre = (m_pre + 1) % TICK;
    m_s = ns; m_m = nm; m_h = nh;
    e.h = m_h; e.m = m_m; e.s = m_s; e.tick = tick;
    e.db = m_db; e.num24 = m_num24; e.num12 = m_num12;
  endtask

  // One clock: drive inputs, queue expectation, compare 1 ns after the edge.
  task automatic step(input bit r, input bit im, input bit ih, input bit cs);
    exp_t e;
    bus24.run = r; bus24.inc_m = im; bus24.inc_h = ih; bus24.clr_s = cs;
    bus12.run = r; bus12.inc_m = im; bus12.inc_h = ih; bus12.clr_s = cs;
    model_step(r, im, ih, cs, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (bus24.sec_tick) tick_seen++;
    check("hours24",   32'(bus24.hours),       32'(e.h));
    check("minutes24", 32'(bus24.minutes),     32'(e.m));
    check("seconds24", 32'(bus24.seconds),     32'(e.s));
    check("tick24",    32'(bus24.sec_tick),    32'(e.tick));
    check("digit24",   32'(bus24.digit_block), 32'(e.db));
    check("number24",  32'(bus24.number),      32'(e.num24));
    check("hours12",   32'(bus12.hours),       32'(e.h));
    check("minutes12", 32'(bus12.minutes),     32'(e.m));
    check("seconds12", 32'(bus12.seconds),     32'(e.s));
    check("tick12",    32'(bus12.sec_tick),    32'(e.tick));
    check("digit12",   32'(bus12.digit_block), 32'(e.db));
    check("number12",  32'(bus12.number),      32'(e.num12));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hours"},   32'(bus24.hours),       32'd0);
    check({tag, "_minutes"}, 32'(bus24.minutes),     32'd0);
    check({tag, "_seconds"}, 32'(bus24.seconds),     32'd0);
    check({tag, "_tick"},    32'(bus24.sec_tick),    32'd0);
    check({tag, "_digit24"}, 32'(bus24.digit_block), 32'h3E);
    check({tag, "_num24"},   32'(bus24.number),      32'hC0);
    check({tag, "_digit12"}, 32'(bus12.digit_block), 32'h3E);
    check({tag, "_num12"},   32'(bus12.number),      32'hC0);
  endtask

  task automatic idle_inputs();
    bus24.run = 1'b0; bus24.inc_m = 1'b0; bus24.inc_h = 1'b0; bus24.clr_s = 1'b0;
    bus12.run = 1'b0; bus12.inc_m = 1'b0; bus12.inc_h = 1'b0; bus12.clr_s = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] one_hot;
    int         seen;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Scan sequence with time frozen at 00:00:00.
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);

    // First second, then first minute.
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sec_after_4", 32'(bus24.seconds), 32'd1);
    repeat (236) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("min_after_240", 32'(bus24.minutes), 32'd1);
    check("sec_after_240", 32'(bus24.seconds), 32'd0);

    // Preload 23:59:59 (simultaneous inc_m/inc_h first), then midnight.
    repeat (23) step(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (35) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (236) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("preload_h", 32'(bus24.hours),   32'd23);
    check("preload_m", 32'(bus24.minutes), 32'd59);
    check("preload_s", 32'(bus24.seconds), 32'd59);
    tick_seen = 0;
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("midnight_ticks", 32'(tick_seen), 32'd1);
    check("midnight_h", 32'(bus24.hours), 32'd0);
    check("midnight_m", 32'(bus24.minutes), 32'd0);

    // inc_m wraps minutes without touching hours.
    repeat (59) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("incm_wrap_m", 32'(bus24.minutes), 32'd0);
    check("incm_wrap_h", 32'(bus24.hours),   32'd0);

    // inc_m coincident with a 59->0 seconds tick: minutes +1 only.
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (239) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("incm_tick_m", 32'(bus24.minutes), 32'd11);
    check("incm_tick_s", 32'(bus24.seconds), 32'd0);

    // clr_s coincident with the tick: no strobe, prescaler restarts.
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("clrs_tick", 32'(bus24.sec_tick), 32'd0);
    check("clrs_sec",  32'(bus24.seconds),  32'd0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("clrs_pre_restart", 32'(bus24.seconds), 32'd1);

    // run low freezes the prescaler mid-count.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_resume_sec", 32'(bus24.seconds), 32'd2);

    // 13:05:00 with run low: 12-hour and 24-hour digit readings.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (13) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (54) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    seen = 0;
    repeat (12) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        one_hot = 6'b000001 << i;
        if (bus12.digit_block == ~one_hot) begin
          seen++;
          check($sformatf("h12_digit%0d", i), 32'(bus12.number), 32'(EXP12[i]));
          check($sformatf("h24_digit%0d", i), 32'(bus24.number), 32'(EXP24[i]));
        end
      end
    end
    check("h12_digits_seen", 32'(seen), 32'd12);

    // Asynchronous reset mid-scan, then a fresh scan and first second.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_sec", 32'(bus24.seconds), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
